wb_stage_seq: RTL and testbench



---
 rtl/wb_stage_seq.sv | 143 ++++++++++++++
 tb/tb_wb_stage_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_seq.sv
// Registered MEM->WB writeback stage: captures a retiring instruction, waits for load data,
// extracts sub-word loads and drives a one-cycle register-file write. Optional: WB_BYPASS_EN.
module wb_stage_seq #(
  parameter int XLEN    = 32,
  parameter int PC_INC  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd_addr,
  input  logic [1:0]      in_mem_to_reg,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            err
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam int OFFW = (XLEN == 64) ? 3 : 2;
  localparam int SHW  = OFFW + 3;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic [4:0]        ld_rd;
  logic [2:0]        ld_f3;
  logic [OFFW-1:0]   ld_off;

  logic              acc, is_ld, to_hit;
  logic [XLEN-1:0]   src_data, ld_data, vb, vh, vw;
  logic [SHW-1:0]    sh_b, sh_h, sh_w;

  assign in_ready = (state != WAIT_MEM);
  assign acc      = in_valid && in_ready;
  assign is_ld    = (in_mem_to_reg == 2'b00) && in_reg_write;
  assign to_hit   = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (acc) nxt = is_ld ? WAIT_MEM : WRITE;
      WRITE:    nxt = acc ? (is_ld ? WAIT_MEM : WRITE) : IDLE;
      WAIT_MEM: if (mem_rvalid) nxt = WRITE;
                else if (to_hit) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Non-load sources; a non-writing "load" keeps the previous data on the bus.
  always_comb begin
    src_data = rf_wdata;
    case (in_mem_to_reg)
      2'b01:   src_data = in_alu_result;
      2'b10:   src_data = in_pc + XLEN'(PC_INC);
      2'b11:   src_data = in_imm;
      default: src_data = rf_wdata;
    endcase
  end

  // Sub-word extraction: shift the selected lane down, then size/extend.
  always_comb begin
    sh_b = {ld_off, 3'b000};
    sh_h = {ld_off[OFFW-1:1], 4'b0000};
    sh_w = '0;
    if (XLEN == 64) sh_w[SHW-1] = ld_off[OFFW-1];
    vb = mem_rdata >> sh_b;
    vh = mem_rdata >> sh_h;
    vw = mem_rdata >> sh_w;
    case (ld_f3)
      3'b000:  ld_data = XLEN'($signed(vb[7:0]));
      3'b100:  ld_data = XLEN'(vb[7:0]);
      3'b001:  ld_data = XLEN'($signed(vh[15:0]));
      3'b101:  ld_data = XLEN'(vh[15:0]);
      3'b010:  ld_data = XLEN'($signed(vw[31:0]));
      3'b110:  ld_data = (XLEN == 64) ? XLEN'(vw[31:0]) : mem_rdata;
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ld_rd    <= '0;
      ld_f3    <= '0;
      ld_off   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      err      <= 1'b0;
    end else begin
      state <= nxt;
      rf_we <= 1'b0;
      err   <= 1'b0;
      if (acc) begin
        if (is_ld) begin
          ld_rd  <= in_rd_addr;
          ld_f3  <= in_funct3;
          ld_off <= in_alu_result[OFFW-1:0];
          cnt    <= '0;
        end else begin
          rf_we    <= in_reg_write && (in_rd_addr != 5'd0);
          rf_waddr <= in_rd_addr;
          rf_wdata <= src_data;
        end
      end else if (state == WAIT_MEM) begin
        // Returning data beats a coincident timeout.
        if (mem_rvalid) begin
          rf_we    <= (ld_rd != 5'd0);
          rf_waddr <= ld_rd;
          rf_wdata <= ld_data;
        end else begin
          cnt <= cnt + 1'b1;
          if (to_hit) err <= 1'b1;
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  // rf_we is already low in WAIT_MEM, so forwarding is suppressed while a load is pending.
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage_seq.sv
// Scoreboard bench for wb_stage_seq (XLEN=32, TIMEOUT=4): expected writes queued at stimulus time.
module tb_wb_stage_seq;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, in_ready, in_reg_write = 1'b0;
  logic [4:0]      in_rd_addr = '0;
  logic [1:0]      in_mem_to_reg = '0;
  logic [2:0]      in_funct3 = '0;
  logic [XLEN-1:0] in_alu_result = '0, in_pc = '0, in_imm = '0, mem_rdata = '0;
  logic            mem_rvalid = 1'b0;
  logic            rf_we, err;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  typedef struct { logic [4:0] a; logic [XLEN-1:0] d; } exp_t;
  exp_t q[$];
  int ncmp = 0, nerr = 0;

  wb_stage_seq #(.XLEN(XLEN), .PC_INC(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr), .in_mem_to_reg(in_mem_to_reg),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result), .in_pc(in_pc), .in_imm(in_imm),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (q.size() == 0) chk("sb_underflow_we", rf_we, 1'b0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_waddr", rf_waddr, e.a);
        chk("sb_wdata", rf_wdata, e.d);
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic push(input logic [4:0] a, input logic [XLEN-1:0] d);
    exp_t e;
    e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] m2r,
                      input logic [2:0] f3, input logic [XLEN-1:0] alu,
                      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
    in_valid = 1'b1; in_reg_write = rw; in_rd_addr = rd; in_mem_to_reg = m2r;
    in_funct3 = f3; in_alu_result = alu; in_pc = pc; in_imm = imm;
  endtask

  task automatic idle; in_valid = 1'b0; endtask

  // Load with data returned k cycles after acceptance; bogus data in the accept cycle is ignored.
  task automatic load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdata,
                      input logic [XLEN-1:0] exp, input int k);
    send(1'b1, rd, 2'b00, f3, alu, '0, '0);
    mem_rvalid = 1'b1; mem_rdata = ~rdata;
    push(rd, exp);
    tick;
    idle; mem_rvalid = 1'b0;
    for (int i = 1; i < k; i++) begin
      chk({tag, "_ready_lo"}, in_ready, 1'b0);
      tick;
    end
    chk({tag, "_ready_lo"}, in_ready, 1'b0);
    chk({tag, "_no_early_we"}, rf_we, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick;
    mem_rvalid = 1'b0;
    chk({tag, "_we"}, rf_we, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    tick;
    chk("rst_ready", in_ready, 1'b1);

    // ALU writeback at T+1, strobe gone at T+2
    send(1'b1, 5'd5, 2'b01, 3'b010, 32'h12345678, '0, '0);
    push(5'd5, 32'h12345678);
    tick; idle;
    chk("alu_we", rf_we, 1'b1);
    tick;
    chk("alu_we_off", rf_we, 1'b0);

    load("lb",  5'd7,  3'b000, 32'h00001003, 32'h80FFFF00, 32'hFFFFFF80, 3);
    load("lhu", 5'd10, 3'b101, 32'h00002002, 32'hBEEF1234, 32'h0000BEEF, 1);
    load("lh",  5'd11, 3'b001, 32'h00002002, 32'hBEEF1234, 32'hFFFFBEEF, 2);
    load("lbu", 5'd12, 3'b100, 32'h00000001, 32'h80FFFF00, 32'h000000FF, 1);
    load("lw",  5'd13, 3'b010, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 1);
    load("f111", 5'd14, 3'b111, 32'h00000003, 32'h13579BDF, 32'h13579BDF, 1);
    tick;

    // back-to-back non-loads: PC wrap, rd=0 immediate, immediate
    send(1'b1, 5'd3, 2'b10, 3'b000, '0, 32'hFFFFFFFC, '0);
    push(5'd3, 32'h00000000);
    tick;
    chk("pc_we", rf_we, 1'b1);
    send(1'b1, 5'd0, 2'b11, 3'b000, '0, '0, 32'hABCDE000);
    tick;
    chk("rd0_we", rf_we, 1'b0);
    chk("rd0_ready", in_ready, 1'b1);
    send(1'b1, 5'd9, 2'b11, 3'b000, '0, '0, 32'hABCDE000);
    push(5'd9, 32'hABCDE000);
    tick;
    chk("imm_we", rf_we, 1'b1);
    // load accepted while the previous instruction is being written
    send(1'b1, 5'd4, 2'b01, 3'b000, 32'h0000BEEF, '0, '0);
    push(5'd4, 32'h0000BEEF);
    tick;
    chk("wr_then_ld_we", rf_we, 1'b1);
    load("ld_in_write", 5'd15, 3'b000, 32'h00000000, 32'h0000007F, 32'h0000007F, 2);
    idle; tick;

    // timeout: 4 WAIT_MEM cycles without data
    send(1'b1, 5'd6, 2'b00, 3'b010, '0, '0, '0);
    tick; idle;
    for (int i = 0; i < 3; i++) begin
      chk("to_ready_lo", in_ready, 1'b0);
      chk("to_err_lo", err, 1'b0);
      tick;
    end
    chk("to_ready_lo", in_ready, 1'b0);
    tick;
    chk("to_err", err, 1'b1);
    chk("to_no_we", rf_we, 1'b0);
    chk("to_ready", in_ready, 1'b1);
    tick;
    chk("to_err_pulse", err, 1'b0);
    // data coincident with the limit wins
    load("to_edge", 5'd16, 3'b010, '0, 32'h55AA55AA, 32'h55AA55AA, 4);
    tick;
    chk("to_edge_err", err, 1'b0);

    // reset during WAIT_MEM, late data ignored
    send(1'b1, 5'd6, 2'b00, 3'b010, '0, '0, '0);
    tick; idle; tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", rf_we, 1'b0);
    chk("mid_rst_waddr", rf_waddr, 5'd0);
    chk("mid_rst_wdata", rf_wdata, 32'h0);
    chk("mid_rst_ready", in_ready, 1'b1);
    tick;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick;
    chk("late_rv_we", rf_we, 1'b0);
    tick;
    mem_rvalid = 1'b0;
    chk("late_rv_we2", rf_we, 1'b0);
    chk("late_rv_wdata", rf_wdata, 32'h0);
    send(1'b1, 5'd8, 2'b01, 3'b000, 32'h00C0FFEE, '0, '0);
    push(5'd8, 32'h00C0FFEE);
    tick; idle;
    chk("post_rst_we", rf_we, 1'b1);
    tick; tick;

    chk("sb_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
